// File: rtl/spi_poll_master_pkg.sv
// Shared types and constants for the polling SPI master and its SCK generator.
// Holds the FSM state type, the SPI phase encodings and a counter-width helper.
package spi_poll_master_pkg;

    localparam int unsigned BYTE_W = 8;

    // CPHA values: which SCK edge of a bit samples miso
    localparam bit CPHA_LEAD_SAMPLE  = 1'b0;
    localparam bit CPHA_TRAIL_SAMPLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/spi_poll_master_sck_gen.sv
// SCK generator: divides clk by CLK_DIV per half-period while enabled.
// Flags the cycle before each leading/trailing SCK edge; idles at CPOL when disabled.
module spi_sck_gen
    import spi_poll_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50,
    parameter bit          CPOL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic lead_tick,
    output logic trail_tick,
    output logic sck
);
    localparam int unsigned DW = cnt_w(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          phase_q, phase_d;
    logic          wrap;

    always_comb begin
        wrap    = en && (div_q == DIV_LAST);
        div_d   = div_q;
        phase_d = phase_q;
        if (!en) begin
            div_d   = '0;
            phase_d = 1'b0;
        end else if (wrap) begin
            div_d   = '0;
            phase_d = ~phase_q;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

    // ticks are asserted in the cycle whose closing edge moves sck
    assign lead_tick  = wrap & ~phase_q;
    assign trail_tick = wrap & phase_q;
    assign sck        = CPOL ^ phase_q;

endmodule

// File: rtl/spi_poll_master.sv
// Parametrised full-duplex SPI burst master with optional free-running auto-poll.
// One burst shifts NBYTES bytes MSB first; the poll re-issues the last explicit command.
module spi_poll_master
    import spi_poll_master_pkg::*;
#(
    parameter int unsigned NBYTES      = 5,
    parameter int unsigned CLK_DIV     = 50,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int unsigned POLL_PERIOD = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [BYTE_W*NBYTES-1:0] tx_data,
    output logic [BYTE_W*NBYTES-1:0] rx_data,
    output logic                     busy,
    output logic                     done,
    output logic                     cs,
    output logic                     mosi,
    input  logic                     miso,
    output logic                     sck
);
    localparam int unsigned W         = BYTE_W * NBYTES;
    localparam int unsigned BCW       = cnt_w(W);
    localparam int unsigned TW        = cnt_w(CLK_DIV - 1);
    localparam int unsigned POLL_LAST = (POLL_PERIOD == 0) ? 0 : POLL_PERIOD - 1;
    localparam int unsigned PW        = cnt_w(POLL_LAST);
    localparam bit          POLL_EN   = (POLL_PERIOD != 0);
    localparam bit          SAMPLE_LEAD = (CPHA == CPHA_LEAD_SAMPLE);
    localparam bit          DRIVE_LEAD  = (CPHA == CPHA_TRAIL_SAMPLE);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(W - 1);
    localparam logic [TW-1:0]  TMR_LAST = TW'(CLK_DIV - 1);
    localparam logic [PW-1:0]  POLL_MAX = PW'(POLL_LAST);

    state_e         state_q, state_d;
    logic           launch_q, launch_d;
    logic [W-1:0]   tx_sh_q, tx_sh_d;
    logic [W-1:0]   cmd_q, cmd_d;
    logic [W-1:0]   rx_sh_q, rx_sh_d;
    logic [W-1:0]   rx_data_q, rx_data_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [PW-1:0]  poll_q, poll_d;
    logic           cs_q, cs_d;
    logic           mosi_q, mosi_d;
    logic           done_q, done_d;
    logic           sck_en, lead_tick, trail_tick;
    logic           can_accept, poll_due, accept;

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV),
        .CPOL    (CPOL)
    ) u_sck_gen (
        .clk        (clk),
        .rst        (rst),
        .en         (sck_en),
        .lead_tick  (lead_tick),
        .trail_tick (trail_tick),
        .sck        (sck)
    );

    assign sck_en = (state_q == ST_SHIFT);

    always_comb begin
        state_d   = state_q;
        launch_d  = launch_q;
        tx_sh_d   = tx_sh_q;
        cmd_d     = cmd_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        tmr_d     = tmr_q;
        poll_d    = poll_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;

        // The poll counter saturates at expiry, so a poll that lands while busy stays pending.
        can_accept = (state_q == ST_IDLE) && !launch_q;
        poll_due   = POLL_EN && (poll_q == POLL_MAX);
        accept     = can_accept && (start || poll_due);

        if (accept) begin
            tx_sh_d  = start ? tx_data : cmd_q;
            cmd_d    = tx_sh_d;
            launch_d = 1'b1;
            poll_d   = '0;
        end else if (POLL_EN && (poll_q != POLL_MAX)) begin
            poll_d = poll_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (launch_q) begin
                    launch_d  = 1'b0;
                    state_d   = ST_SETUP;
                    cs_d      = 1'b0;
                    mosi_d    = tx_sh_q[W-1];
                    tmr_d     = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_SETUP: begin
                if (tmr_q == TMR_LAST) begin
                    state_d = ST_SHIFT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (lead_tick) begin
                    if (SAMPLE_LEAD) begin
                        rx_sh_d = {rx_sh_q[W-2:0], miso};
                    end
                    if (DRIVE_LEAD) begin
                        mosi_d  = tx_sh_q[W-1];
                        tx_sh_d = tx_sh_q << 1;
                    end
                end
                if (trail_tick) begin
                    if (!SAMPLE_LEAD) begin
                        rx_sh_d = {rx_sh_q[W-2:0], miso};
                    end
                    if (!DRIVE_LEAD && (bit_cnt_q != BIT_LAST)) begin
                        mosi_d  = tx_sh_q[W-2];
                        tx_sh_d = tx_sh_q << 1;
                    end
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (tmr_q == TMR_LAST) begin
                    state_d   = ST_GAP;
                    tmr_d     = '0;
                    cs_d      = 1'b1;
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_q == TMR_LAST) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            launch_q  <= 1'b0;
            tx_sh_q   <= '0;
            cmd_q     <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            tmr_q     <= '0;
            poll_q    <= '0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            launch_q  <= launch_d;
            tx_sh_q   <= tx_sh_d;
            cmd_q     <= cmd_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            tmr_q     <= tmr_d;
            poll_q    <= poll_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign cs      = cs_q;
    assign mosi    = mosi_q;
    assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_poll_master.sv
// Bench for spi_poll_master: four SPI modes side by side (mode 0 in loopback) plus an auto-poll instance.
// Expected bursts are queued when a start is driven and retired when done pulses.
module tb_spi_poll_master;

    localparam int unsigned NB       = 5;
    localparam int unsigned CDIV     = 4;
    localparam int unsigned CS_LOW   = CDIV * (2 + 16 * NB);
    localparam int unsigned PCDIV    = 2;
    localparam int unsigned PPERIOD  = 500;
    localparam int unsigned P_LAT    = 1 + PCDIV * (2 + 16 * 1);

    typedef struct {
        logic [39:0] tx;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    logic        rst_m, start_m;
    logic [39:0] tx_m;
    logic [39:0] rx_m [4];
    logic        busy_m [4], done_m [4], cs_m [4], mosi_m [4], miso_m [4], sck_m [4];
    logic        cpol_m [4];
    logic [39:0] cap_m [4];
    logic [39:0] slave_word = 40'h12_34_56_78_9A;

    logic        rst_p, start_p, busy_p, done_p, cs_p, mosi_p, sck_p;
    logic [7:0]  tx_p, rx_p;

    exp_t        exp_q[$];
    exp_t        exp_p[$];
    exp_t        item, pitem;
    int unsigned cs_low_len = 0;
    logic [3:0]  dv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_mode
        localparam bit P_CPOL = ((gi / 2) % 2) == 1;
        localparam bit P_CPHA = (gi % 2) == 1;
        logic        sck_prev = P_CPOL;
        logic        cs_prev  = 1'b1;
        logic        lead, trail, miso_s;
        logic [39:0] cap;
        int unsigned idx;

        spi_poll_master #(
            .NBYTES      (NB),
            .CLK_DIV     (CDIV),
            .CPOL        (P_CPOL),
            .CPHA        (P_CPHA),
            .POLL_PERIOD (0)
        ) u_dut (
            .clk     (clk),
            .rst     (rst_m),
            .start   (start_m),
            .tx_data (tx_m),
            .rx_data (rx_m[gi]),
            .busy    (busy_m[gi]),
            .done    (done_m[gi]),
            .cs      (cs_m[gi]),
            .mosi    (mosi_m[gi]),
            .miso    (miso_m[gi]),
            .sck     (sck_m[gi])
        );

        // slave: records mosi on the sampling edge, drives slave_word on the launch edge
        always @(negedge clk) begin
            if (cs_m[gi] !== 1'b0) begin
                idx    = 0;
                miso_s = slave_word[39];
            end else begin
                if (cs_prev) cap = '0;
                lead  = (sck_prev == P_CPOL) && (sck_m[gi] != P_CPOL);
                trail = (sck_prev != P_CPOL) && (sck_m[gi] == P_CPOL);
                if ((lead && !P_CPHA) || (trail && P_CPHA)) cap = {cap[38:0], mosi_m[gi]};
                if (P_CPHA) begin
                    if (lead && idx < 40) begin
                        miso_s = slave_word[39 - idx];
                        idx++;
                    end
                end else begin
                    if (trail) idx++;
                    if (idx < 40) miso_s = slave_word[39 - idx];
                end
            end
            sck_prev = sck_m[gi];
            cs_prev  = cs_m[gi];
        end

        assign cap_m[gi]  = cap;
        assign cpol_m[gi] = P_CPOL;
        if (gi == 0) begin : g_loop
            assign miso_m[gi] = mosi_m[gi];
        end else begin : g_slave
            assign miso_m[gi] = miso_s;
        end
    end

    spi_poll_master #(
        .NBYTES      (1),
        .CLK_DIV     (PCDIV),
        .CPOL        (1'b0),
        .CPHA        (1'b0),
        .POLL_PERIOD (PPERIOD)
    ) u_poll (
        .clk     (clk),
        .rst     (rst_p),
        .start   (start_p),
        .tx_data (tx_p),
        .rx_data (rx_p),
        .busy    (busy_p),
        .done    (done_p),
        .cs      (cs_p),
        .mosi    (mosi_p),
        .miso    (mosi_p),
        .sck     (sck_p)
    );

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) dv[i] = done_m[i];
        if (dv != 4'b0) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 64'(dv), 64'd0);
            end else begin
                item = exp_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(item.cyc));
                chk("cs_low_len", 64'(cs_low_len), 64'(CS_LOW));
                for (int i = 0; i < 4; i++) begin
                    chk("done_all", 64'(dv[i]), 64'd1);
                    chk("rx_data", 64'(rx_m[i]), 64'((i == 0) ? item.tx : slave_word));
                    chk("mosi_stream", 64'(cap_m[i]), 64'(item.tx));
                end
            end
        end
        if (cs_m[0] !== 1'b0) cs_low_len = 0;
        else cs_low_len++;
        for (int i = 0; i < 4; i++)
            if (cs_m[i] === 1'b1) chk("sck_idle", 64'(sck_m[i]), 64'(cpol_m[i]));
    end

    always @(negedge clk) begin
        if (done_p === 1'b1) begin
            if (exp_p.size() == 0) begin
                chk("poll_spurious_done", 64'(done_p), 64'd0);
            end else begin
                pitem = exp_p.pop_front();
                chk("poll_rx", 64'(rx_p), 64'(pitem.tx));
                chk("poll_cycle", 64'(cyc), 64'(pitem.cyc));
            end
        end
    end

    task automatic pulse_start_m(input logic [39:0] tx, input bit expect_it);
        @(negedge clk);
        tx_m    = tx;
        start_m = 1'b1;
        if (expect_it) exp_q.push_back('{tx: tx, cyc: cyc + 1 + 1 + CS_LOW});
        @(negedge clk);
        start_m = 1'b0;
    endtask

    initial begin
        int unsigned c0;
        rst_m   = 1'b1;
        rst_p   = 1'b1;
        start_m = 1'b0;
        start_p = 1'b0;
        tx_m    = '0;
        tx_p    = '0;
        repeat (3) @(negedge clk);
        rst_m = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("reset_cs", 64'(cs_m[i]), 64'd1);
            chk("reset_sck", 64'(sck_m[i]), 64'(cpol_m[i]));
            chk("reset_mosi", 64'(mosi_m[i]), 64'd0);
            chk("reset_busy", 64'(busy_m[i]), 64'd0);
            chk("reset_done", 64'(done_m[i]), 64'd0);
            chk("reset_rx", 64'(rx_m[i]), 64'd0);
        end

        pulse_start_m(40'hA5_3C_00_FF_81, 1'b1);
        repeat (340) @(negedge clk);
        chk("burst1_pending", 64'(exp_q.size()), 64'd0);

        // second start lands mid-burst with different data and must be dropped
        pulse_start_m(40'h0F_1E_2D_3C_4B, 1'b1);
        repeat (8) @(negedge clk);
        pulse_start_m(40'hF0_E1_D2_C3_B4, 1'b0);
        chk("busy_during_burst", 64'(busy_m[0]), 64'd1);
        repeat (340) @(negedge clk);
        chk("busy_ignore_pending", 64'(exp_q.size()), 64'd0);

        // abort during bit 17
        pulse_start_m(40'h66_77_88_99_AA, 1'b1);
        repeat (143) @(negedge clk);
        rst_m = 1'b1;
        @(negedge clk);
        rst_m = 1'b0;
        void'(exp_q.pop_back());
        for (int i = 0; i < 4; i++) begin
            chk("abort_cs", 64'(cs_m[i]), 64'd1);
            chk("abort_sck", 64'(sck_m[i]), 64'(cpol_m[i]));
            chk("abort_busy", 64'(busy_m[i]), 64'd0);
            chk("abort_rx", 64'(rx_m[i]), 64'd0);
            chk("abort_done", 64'(done_m[i]), 64'd0);
        end
        repeat (20) @(negedge clk);
        pulse_start_m(40'hC0_FF_EE_00_11, 1'b1);
        repeat (340) @(negedge clk);
        chk("after_abort_pending", 64'(exp_q.size()), 64'd0);

        rst_p = 1'b0;
        repeat (5) @(negedge clk);
        @(negedge clk);
        c0      = cyc;
        tx_p    = 8'h5A;
        start_p = 1'b1;
        for (int unsigned j = 0; j < 4; j++)
            exp_p.push_back('{tx: 40'h5A, cyc: c0 + 1 + P_LAT + PPERIOD * j});
        @(negedge clk);
        start_p = 1'b0;
        tx_p    = 8'h00;
        while (cyc < c0 + 4 * PPERIOD) @(negedge clk);
        // user start in the same cycle as the fifth poll expiry
        tx_p    = 8'hC3;
        start_p = 1'b1;
        for (int unsigned j = 4; j < 7; j++)
            exp_p.push_back('{tx: 40'hC3, cyc: c0 + 1 + P_LAT + PPERIOD * j});
        @(negedge clk);
        start_p = 1'b0;
        tx_p    = 8'h00;
        while (cyc < c0 + 6 * PPERIOD + 100) @(negedge clk);
        chk("poll_pending", 64'(exp_p.size()), 64'd0);
        rst_p = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
